// File: rtl/sha_w_window_pkg.sv
// Shared definitions for the SHA-256 message-schedule window:
// FSM state encoding, window geometry and the fixed tap offsets.
package sha_w_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Window geometry: 16 words, oldest at index 0.
    localparam int WIN_DEPTH = 16;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 3;

    // Tap positions inside the window for W[t-16], W[t-15], W[t-7], W[t-2].
    localparam int TAP_W16 = 0;
    localparam int TAP_W15 = 1;
    localparam int TAP_W7  = 9;
    localparam int TAP_W2  = 14;

endpackage

// File: rtl/sha_w_window_if.sv
// Bus bundle between the schedule window, its message source, the M_Stage
// unit and the compression rounds.
//
// Handshake: a message word moves on every rising clk edge where msg_valid
// and msg_ready are both high; msg_data must be stable while msg_valid is
// high. The wt_* stream has no ready: wt_valid is a one-cycle pulse that the
// consumer must take when it appears.
interface sha_w_window_if
    import sha_w_window_pkg::*;
#(
    parameter int DATA_W = 32
) ();

    logic              run;
    logic              done;
    logic              msg_valid;
    logic              msg_ready;
    logic [DATA_W-1:0] msg_data;
    logic [DATA_W-1:0] w16;
    logic [DATA_W-1:0] w15;
    logic [DATA_W-1:0] w7;
    logic [DATA_W-1:0] w2;
    logic [DATA_W-1:0] w_new;
    logic              wt_valid;
    logic [DATA_W-1:0] wt_data;
    logic [IDX_W-1:0]  wt_idx;

    // Window side.
    modport slave (
        input  run, msg_valid, msg_data, w_new,
        output done, msg_ready, w16, w15, w7, w2, wt_valid, wt_data, wt_idx
    );

    // Environment side (message source, M_Stage, rounds).
    modport master (
        output run, msg_valid, msg_data, w_new,
        input  done, msg_ready, w16, w15, w7, w2, wt_valid, wt_data, wt_idx
    );

endinterface

// File: rtl/sha_w_window_shreg.sv
// 16-deep word shift register: win[i] <= win[i+1], win[15] <= new word,
// with four fixed tap outputs feeding M_Stage.
module sha_w_shreg
    import sha_w_window_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] shift_word_i,
    output logic [DATA_W-1:0] tap16_o,
    output logic [DATA_W-1:0] tap15_o,
    output logic [DATA_W-1:0] tap7_o,
    output logic [DATA_W-1:0] tap2_o
);

    logic [DATA_W-1:0] win_q [WIN_DEPTH];
    logic [DATA_W-1:0] win_d [WIN_DEPTH];

    // Next window contents: hold, or move every word one slot older.
    always_comb begin
        for (int i = 0; i < WIN_DEPTH; i++) begin
            win_d[i] = win_q[i];
        end
        if (shift_en_i) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[WIN_DEPTH-1] = shift_word_i;
        end
    end

    // Window storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign tap16_o = win_q[TAP_W16];
    assign tap15_o = win_q[TAP_W15];
    assign tap7_o  = win_q[TAP_W7];
    assign tap2_o  = win_q[TAP_W2];

endmodule

// File: rtl/sha_w_window.sv
// SHA-256 message-schedule window. Loads the 16 message words of a block,
// presents the recurrence taps to M_Stage, shifts each M_Stage result back
// in, and streams W[0..NUM_ROUNDS-1] in order to the compression rounds.
module sha_w_window
    import sha_w_window_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_ROUNDS = 64,
    parameter int MSTAGE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    sha_w_window_if.slave    bus,
    output state_e           dbg_state_o
);

    localparam logic [IDX_W-1:0] LAST_MSG_T = IDX_W'(WIN_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_T     = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MSTAGE_LAT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  t_q, t_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wt_valid_q, wt_valid_d;
    logic [DATA_W-1:0] wt_data_q, wt_data_d;
    logic [IDX_W-1:0]  wt_idx_q, wt_idx_d;

    logic              shift_en;
    logic [DATA_W-1:0] shift_word;

    logic [DATA_W-1:0] tap16, tap15, tap7, tap2;

    sha_w_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk          (clk),
        .rst          (rst),
        .shift_en_i   (shift_en),
        .shift_word_i (shift_word),
        .tap16_o      (tap16),
        .tap15_o      (tap15),
        .tap7_o       (tap7),
        .tap2_o       (tap2)
    );

    // Sequencing: message load, then one M_Stage capture every
    // MSTAGE_LAT+1 cycles; every word shifted in is echoed on wt next cycle.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        cnt_d      = cnt_q;
        wt_valid_d = 1'b0;
        wt_data_d  = wt_data_q;
        wt_idx_d   = wt_idx_q;
        shift_en   = 1'b0;
        shift_word = bus.msg_data;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (bus.run) begin
                    state_d = ST_LOAD;
                    t_d     = '0;
                end
            end

            ST_LOAD: begin
                if (bus.msg_valid) begin
                    shift_en   = 1'b1;
                    shift_word = bus.msg_data;
                    wt_valid_d = 1'b1;
                    wt_data_d  = bus.msg_data;
                    wt_idx_d   = t_q;
                    t_d        = t_q + IDX_W'(1);
                    if (t_q == LAST_MSG_T) begin
                        state_d = ST_CALC;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end

            ST_CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_en   = 1'b1;
                    shift_word = bus.w_new;
                    wt_valid_d = 1'b1;
                    wt_data_d  = bus.w_new;
                    wt_idx_d   = t_q;
                    cnt_d      = LAT_LOAD;
                    // t stops at the last index instead of wrapping.
                    if (t_q == LAST_T) begin
                        state_d = ST_FIN;
                    end else begin
                        t_d = t_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and the registered wt stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            cnt_q      <= '0;
            wt_valid_q <= 1'b0;
            wt_data_q  <= '0;
            wt_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            cnt_q      <= cnt_d;
            wt_valid_q <= wt_valid_d;
            wt_data_q  <= wt_data_d;
            wt_idx_q   <= wt_idx_d;
        end
    end

    assign bus.done      = (state_q == ST_IDLE) || (state_q == ST_FIN);
    assign bus.msg_ready = (state_q == ST_LOAD);
    assign bus.w16       = tap16;
    assign bus.w15       = tap15;
    assign bus.w7        = tap7;
    assign bus.w2        = tap2;
    assign bus.wt_valid  = wt_valid_q;
    assign bus.wt_data   = wt_data_q;
    assign bus.wt_idx    = wt_idx_q;
    assign dbg_state_o   = state_q;

endmodule
